vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 90 +++++++++
 tb/tb_vga_sync_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: clk/2 pixel strobe, pixel/line counters,
// sync/blank decodes aligned with the counters, line/frame strobes and a frame counter.
module vga_sync_gen #(
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       pixel_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_tick,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_VIS + V_FP + V_SYNC);

   logic [9:0] r_hcount;
   logic [9:0] r_vcount;
   logic       r_pixel_tick;
   logic [7:0] r_frame_count;

   logic w_advance;
   logic w_h_end;
   logic w_v_end;
   logic w_line_end;
   logic w_frame_end;

   assign w_advance   = en & r_pixel_tick;
   assign w_h_end     = (r_hcount == H_LAST);
   assign w_v_end     = (r_vcount == V_LAST);
   assign w_line_end  = w_advance & w_h_end;
   assign w_frame_end = w_line_end & w_v_end;

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hcount      <= '0;
         r_vcount      <= '0;
         r_pixel_tick  <= 1'b0;
         r_frame_count <= '0;
      end else if (en) begin
         r_pixel_tick <= ~r_pixel_tick;
         if (r_pixel_tick) begin
            if (w_h_end) begin
               r_hcount <= '0;
               r_vcount <= w_v_end ? '0 : r_vcount + 10'd1;
            end else begin
               r_hcount <= r_hcount + 10'd1;
            end
         end
         if (w_frame_end) begin
            r_frame_count <= r_frame_count + 8'd1;
         end
      end
   end

   // Decodes are taken straight from the counter registers so they line up with hcount/vcount.
   assign hsync       = ~((r_hcount >= H_SYNC_BEG) && (r_hcount < H_SYNC_END));
   assign vsync       = ~((r_vcount >= V_SYNC_BEG) && (r_vcount < V_SYNC_END));
   assign video_on    = (r_hcount < 10'(H_VIS)) && (r_vcount < 10'(V_VIS));
   assign line_tick   = w_line_end;
   assign frame_tick  = w_frame_end;

   assign hcount      = r_hcount;
   assign vcount      = r_vcount;
   assign pixel_tick  = r_pixel_tick;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a shrunken-geometry instance share
// stimulus; a reference model feeds per-cycle expectations through scoreboard queues.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       pt;
      logic [7:0] fc;
      logic       hs;
      logic       vs;
      logic       von;
      logic       lt;
      logic       ft;
   } obs_t;

   typedef struct {
      int h;
      int v;
      int fc;
      bit pt;
   } mdl_t;

   typedef struct {
      int hv, hfp, hsy, ht, vv, vfp, vsy, vt;
   } geo_t;

   logic clk;
   logic reset;
   logic en;

   logic [9:0] b_h, b_v, s_h, s_v;
   logic [7:0] b_fc, s_fc;
   logic       b_pt, b_hs, b_vs, b_von, b_lt, b_ft;
   logic       s_pt, s_hs, s_vs, s_von, s_lt, s_ft;

   obs_t obs_big, obs_sml;
   assign obs_big = {b_h, b_v, b_pt, b_fc, b_hs, b_vs, b_von, b_lt, b_ft};
   assign obs_sml = {s_h, s_v, s_pt, s_fc, s_hs, s_vs, s_von, s_lt, s_ft};

   vga_sync_gen dut_big (
      .clk(clk), .reset(reset), .en(en),
      .hcount(b_h), .vcount(b_v), .pixel_tick(b_pt),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
      .line_tick(b_lt), .frame_tick(b_ft), .frame_count(b_fc)
   );

   // Tiny geometry (8 x 6 pixels, 96 clk per frame) so whole frames and the
   // frame_count wrap fit in a short run.
   vga_sync_gen #(
      .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_sml (
      .clk(clk), .reset(reset), .en(en),
      .hcount(s_h), .vcount(s_v), .pixel_tick(s_pt),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
      .line_tick(s_lt), .frame_tick(s_ft), .frame_count(s_fc)
   );

   localparam int SML_FRAME_CLK = 8 * 6 * 2;

   geo_t g_big = '{640, 16, 96, 800, 480, 10, 2, 525};
   geo_t g_sml = '{4, 1, 2, 8, 3, 1, 1, 6};

   mdl_t m_big, m_sml;
   mdl_t m_rst = '{0, 0, 0, 1'b0};
   obs_t q_big[$];
   obs_t q_sml[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int ft_cnt   = 0;
   int vs_low   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic mdl_t step(input mdl_t s, input bit e, input bit r, input geo_t g);
      mdl_t n = s;
      if (r) return '{0, 0, 0, 1'b0};
      if (e) begin
         n.pt = !s.pt;
         if (s.pt) begin
            if (s.h == g.ht - 1) begin
               n.h = 0;
               n.v = (s.v == g.vt - 1) ? 0 : s.v + 1;
               if (s.v == g.vt - 1) n.fc = (s.fc + 1) % 256;
            end else begin
               n.h = s.h + 1;
            end
         end
      end
      return n;
   endfunction

   function automatic obs_t expect_of(input mdl_t s, input bit e, input geo_t g);
      obs_t o;
      o.h   = 10'(s.h);
      o.v   = 10'(s.v);
      o.pt  = s.pt;
      o.fc  = 8'(s.fc);
      o.hs  = !((s.h >= g.hv + g.hfp) && (s.h < g.hv + g.hfp + g.hsy));
      o.vs  = !((s.v >= g.vv + g.vfp) && (s.v < g.vv + g.vfp + g.vsy));
      o.von = (s.h < g.hv) && (s.v < g.vv);
      o.lt  = e && s.pt && (s.h == g.ht - 1);
      o.ft  = o.lt && (s.v == g.vt - 1);
      return o;
   endfunction

   // One clock: drive at the falling edge, predict, sample 1 time unit after the rising edge.
   task automatic cycle(input bit e, input bit r);
      @(negedge clk);
      en    = e;
      reset = r;
      m_big = step(m_big, e, r, g_big);
      m_sml = step(m_sml, e, r, g_sml);
      q_big.push_back(expect_of(m_big, e, g_big));
      q_sml.push_back(expect_of(m_sml, e, g_sml));
      @(posedge clk);
      #1;
      check("big_cycle", obs_big, q_big.pop_front());
      check("sml_cycle", obs_sml, q_sml.pop_front());
      cyc++;
      if (s_ft) ft_cnt++;
      if (!s_vs) vs_low++;
   endtask

   task automatic run_until_big(input int h, input int v, input bit pt, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (b_h == 10'(h) && b_v == 10'(v) && b_pt == pt) return;
         cycle(1'b1, 1'b0);
      end
      check("run_until_timeout", 64'd1, 64'd0);
   endtask

   task automatic release_and_start();
      cycle(1'b1, 1'b0);
      check("rel_edge1_h", b_h, 0);
      check("rel_edge1_pt", b_pt, 1);
      cycle(1'b1, 1'b0);
      check("rel_edge2_h", b_h, 1);
      check("rel_edge2_pt", b_pt, 0);
   endtask

   initial begin
      int hs_low;
      reset = 1'b1;
      en    = 1'b0;
      m_big = m_rst;
      m_sml = m_rst;
      #1;
      check("rst_state_big", obs_big, expect_of(m_rst, 1'b0, g_big));
      check("rst_state_sml", obs_sml, expect_of(m_rst, 1'b0, g_sml));
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);

      // First frame of the small instance, counted from reset release.
      cyc = 0; ft_cnt = 0; vs_low = 0;
      release_and_start();
      while (cyc < SML_FRAME_CLK) begin
         if (s_ft) begin
            check("sml_ft_pos_h", s_h, 7);
            check("sml_ft_pos_v", s_v, 5);
         end
         cycle(1'b1, 1'b0);
      end
      check("sml_frame_ticks", ft_cnt, 1);
      check("sml_vsync_low_clk", vs_low, 16);
      check("sml_wrap_h", s_h, 0);
      check("sml_wrap_v", s_v, 0);
      check("sml_frame_count", s_fc, 1);

      // Freeze at hcount=300 for 37 clk, then resume.
      run_until_big(300, 0, 1'b0, 2000);
      repeat (37) cycle(1'b0, 1'b0);
      check("freeze_h", b_h, 300);
      check("freeze_pt", b_pt, 0);
      cycle(1'b1, 1'b0);
      check("resume_edge1_h", b_h, 300);
      cycle(1'b1, 1'b0);
      check("resume_edge2_h", b_h, 301);

      // Horizontal sync pulse width and position.
      run_until_big(655, 0, 1'b1, 2000);
      hs_low = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(1'b1, 1'b0);
         if (!b_hs) hs_low++;
         else if (hs_low > 0) break;
      end
      check("hsync_low_clk", hs_low, 192);
      check("hsync_rise_h", b_h, 752);

      // Line wrap at the end of line 10.
      run_until_big(799, 10, 1'b1, 20000);
      check("line_tick_at_799", b_lt, 1);
      cycle(1'b1, 1'b0);
      check("line_wrap_h", b_h, 0);
      check("line_wrap_v", b_v, 11);
      check("line_tick_clear", b_lt, 0);

      // Asynchronous reset between edges, then the release sequence again.
      run_until_big(100, 11, 1'b1, 2000);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      m_big = m_rst;
      m_sml = m_rst;
      check("async_rst_big", obs_big, expect_of(m_rst, en, g_big));
      check("async_rst_sml", obs_sml, expect_of(m_rst, en, g_sml));
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      cyc = 0; ft_cnt = 0;
      release_and_start();

      // frame_count wrap on the small instance.
      while (cyc < 255 * SML_FRAME_CLK) cycle(1'b1, 1'b0);
      check("sml_fc_255", s_fc, 255);
      while (cyc < 256 * SML_FRAME_CLK) cycle(1'b1, 1'b0);
      check("sml_fc_wrap", s_fc, 0);
      check("sml_ft_total", ft_cnt, 256);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
